// File: rtl/cam_i2c_bus_arbiter.sv
// Round-robin arbiter for the shared camera I2C bus.
// Flow: one owner holds the bus, then a forced bus-idle holdoff, then the
// next owner is chosen. A stuck owner is revoked after a timeout.
// The pad drive is registered and is released whenever the bus leaves GRANT.
module cam_i2c_bus_arbiter #(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int HOLDOFF_CYCLES = 250
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic [N_REQ-1:0]         iREQ,
  input  logic [N_REQ-1:0]         iDONE,
  input  logic [N_REQ-1:0]         iSCL,
  input  logic [N_REQ-1:0]         iSDA_OE,
  output logic [N_REQ-1:0]         oGNT,
  output logic [$clog2(N_REQ)-1:0] oOWNER,
  output logic                     oBUSY,
  output logic                     oTIMEOUT,
  output logic                     oSCL,
  output logic                     oSDA_OE
);
  localparam int OW = $clog2(N_REQ);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, GRANT, HOLDOFF} state_t;

  state_t            state, nxt;
  logic [OW-1:0]     last_q, last_d, owner_d, pick;
  logic [N_REQ-1:0]  gnt_d;
  logic [TW-1:0]     tcnt, tcnt_d;
  logic [HW-1:0]     hcnt, hcnt_d;
  logic              to_d, scl_d, sda_d, found, rel;

  // First requester after the last owner, scanning cyclically.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      logic [OW-1:0] idx;
      idx = OW'((int'(last_q) + k) % N_REQ);
      if (!found && iREQ[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // The owner releases by strobing done or by dropping its request.
  assign rel = iDONE[oOWNER] | ~iREQ[oOWNER];

  // State register and registered outputs.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= IDLE;
      oGNT     <= '0;
      oOWNER   <= '0;
      last_q   <= OW'(N_REQ - 1);
      tcnt     <= '0;
      hcnt     <= '0;
      oTIMEOUT <= 1'b0;
      oSCL     <= 1'b1;
      oSDA_OE  <= 1'b0;
    end else begin
      state    <= nxt;
      oGNT     <= gnt_d;
      oOWNER   <= owner_d;
      last_q   <= last_d;
      tcnt     <= tcnt_d;
      hcnt     <= hcnt_d;
      oTIMEOUT <= to_d;
      oSCL     <= scl_d;
      oSDA_OE  <= sda_d;
    end
  end

  // Next state, counters and pad drive. The pad is passed through only while
  // the grant continues, so the release/revoke edge already idles the bus.
  always_comb begin
    nxt     = state;
    gnt_d   = oGNT;
    owner_d = oOWNER;
    last_d  = last_q;
    tcnt_d  = tcnt;
    hcnt_d  = hcnt;
    to_d    = 1'b0;
    scl_d   = 1'b1;
    sda_d   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          nxt         = GRANT;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          owner_d     = pick;
          last_d      = pick;
          tcnt_d      = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          // A release on the terminal cycle wins over the timeout.
          nxt    = HOLDOFF;
          gnt_d  = '0;
          hcnt_d = '0;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          nxt    = HOLDOFF;
          gnt_d  = '0;
          hcnt_d = '0;
          to_d   = 1'b1;
        end else begin
          tcnt_d = tcnt + TW'(1);
          scl_d  = iSCL[oOWNER];
          sda_d  = iSDA_OE[oOWNER];
        end
      end
      HOLDOFF: begin
        if (hcnt == HW'(HOLDOFF_CYCLES - 1)) nxt = IDLE;
        else hcnt_d = hcnt + HW'(1);
      end
      default: nxt = IDLE;
    endcase
  end

  assign oBUSY = (state != IDLE);

endmodule
